// File: rtl/plot_arbiter.sv
// plot_arbiter: burst-locked arbiter sharing the VGA pixel-write port among three requesters.
// Define PLOT_ARB_ROUND_ROBIN_EN for round-robin idle selection; otherwise fixed priority 0 > 1 > 2.
module plot_arbiter #(
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int C_W          = 3,
  parameter int MAX_X        = 160,
  parameter int MAX_Y        = 120,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       req_valid,
  input  logic [2:0]       req_last,
  input  logic [3*X_W-1:0] req_x,
  input  logic [3*Y_W-1:0] req_y,
  input  logic [3*C_W-1:0] req_colour,
  output logic [2:0]       req_ready,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [C_W-1:0]   colour_out,
  output logic             plot,
  output logic [2:0]       gnt,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [1:0]       start, cand, sel, beat_id;
  logic             sel_any, accept, timeout_fire, in_range;
  logic [X_W-1:0]   beat_x;
  logic [Y_W-1:0]   beat_y;
  logic [C_W-1:0]   beat_c;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

`ifdef PLOT_ARB_ROUND_ROBIN_EN
  logic [1:0] last_owner;

  // Resets to 2 so the first search starts at requester 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_owner <= 2'd2;
    else if ((accept && req_last[beat_id]) || timeout_fire)
      last_owner <= beat_id;
  end

  assign start = wrap3({1'b0, last_owner} + 3'd1);
`else
  assign start = 2'd0;
`endif

  // Scan from the farthest candidate back to start so the nearest valid one wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel  = start;
    cand = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = wrap3({1'b0, start} + 3'(k));
      if (req_valid[cand]) sel = cand;
    end
  end

  assign sel_any = |req_valid;

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    idle_cnt_nxt = idle_cnt;
    req_ready    = '0;
    timeout_fire = 1'b0;
    beat_id      = owner;
    case (state)
      IDLE: begin
        beat_id = sel;
        if (sel_any) begin
          req_ready = 3'b001 << sel;
          if (!req_last[sel]) begin
            state_nxt    = LOCKED;
            owner_nxt    = sel;
            idle_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        req_ready = 3'b001 << owner;
        if (req_valid[owner]) begin
          if (req_last[owner]) state_nxt = IDLE;
          else                 idle_cnt_nxt = '0;
        end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          // This idle cycle is the LOCK_TIMEOUT-th in a row.
          state_nxt    = IDLE;
          timeout_fire = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = |(req_valid & req_ready);
  assign beat_x   = req_x[beat_id*X_W +: X_W];
  assign beat_y   = req_y[beat_id*Y_W +: Y_W];
  assign beat_c   = req_colour[beat_id*C_W +: C_W];
  assign in_range = ({1'b0, beat_x} < (X_W+1)'(MAX_X)) && ({1'b0, beat_y} < (Y_W+1)'(MAX_Y));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= 2'd0;
      idle_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      owner    <= owner_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Clipped beats are still consumed; they just never raise plot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_out       <= '0;
      y_out       <= '0;
      colour_out  <= '0;
      plot        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      plot        <= accept && in_range;
      timeout_err <= timeout_fire;
      if (accept) begin
        x_out      <= beat_x;
        y_out      <= beat_y;
        colour_out <= beat_c;
      end
    end
  end

  assign busy = (state == LOCKED);
  assign gnt  = busy ? (3'b001 << owner) : 3'b000;

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: directed vectors, literal checks and a per-cycle reference model.
// Honours PLOT_ARB_ROUND_ROBIN_EN to match the DUT build.
module tb_plot_arbiter;

  localparam int X_W = 8, Y_W = 7, C_W = 3;
  localparam int MAX_X = 160, MAX_Y = 120, LOCK_TIMEOUT = 64;
`ifdef PLOT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       req_valid, req_last, req_ready, gnt;
  logic [3*X_W-1:0] req_x;
  logic [3*Y_W-1:0] req_y;
  logic [3*C_W-1:0] req_colour;
  logic [X_W-1:0]   x_out;
  logic [Y_W-1:0]   y_out;
  logic [C_W-1:0]   colour_out;
  logic             plot, busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  plot_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_X(MAX_X), .MAX_Y(MAX_Y),
                 .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(req_ready),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
    .gnt(gnt), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit l, input int x, input int y, input int c);
    req_valid[i]           = v;
    req_last[i]            = l;
    req_x[i*X_W +: X_W]    = x[X_W-1:0];
    req_y[i*Y_W +: Y_W]    = y[Y_W-1:0];
    req_colour[i*C_W +: C_W] = c[C_W-1:0];
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Reference model: who may go, what gets plotted, and how long the owner has been silent.
  bit             m_locked;
  int             m_owner, m_idle, m_last;
  logic           e_plot, e_terr;
  logic [X_W-1:0] e_x;
  logic [Y_W-1:0] e_y;
  logic [C_W-1:0] e_c;

  initial begin
    forever begin : monitor
      int a, start, r, xs, ys;
      logic [2:0] e_ready, e_gnt;
      @(negedge clk);
      if (!reset_n) begin
        m_locked = 1'b0; m_owner = 0; m_idle = 0; m_last = 2;
        e_plot = 1'b0; e_terr = 1'b0; e_x = '0; e_y = '0; e_c = '0;
      end else begin
        a = -1;
        e_ready = 3'b000;
        if (!m_locked) begin
          start = RR ? (m_last + 1) % 3 : 0;
          for (int k = 0; k < 3; k++) begin
            r = (start + k) % 3;
            if (a < 0 && req_valid[r]) a = r;
          end
          if (a >= 0) e_ready[a] = 1'b1;
        end else begin
          e_ready[m_owner] = 1'b1;
          if (req_valid[m_owner]) a = m_owner;
        end
        e_gnt = 3'b000;
        if (m_locked) e_gnt[m_owner] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("busy", 32'(busy), 32'(m_locked));
        check("plot", 32'(plot), 32'(e_plot));
        check("x_out", 32'(x_out), 32'(e_x));
        check("y_out", 32'(y_out), 32'(e_y));
        check("colour_out", 32'(colour_out), 32'(e_c));
        check("timeout_err", 32'(timeout_err), 32'(e_terr));

        e_terr = 1'b0;
        if (a >= 0) begin
          xs     = int'(req_x[a*X_W +: X_W]);
          ys     = int'(req_y[a*Y_W +: Y_W]);
          e_plot = (xs < MAX_X) && (ys < MAX_Y);
          e_x    = req_x[a*X_W +: X_W];
          e_y    = req_y[a*Y_W +: Y_W];
          e_c    = req_colour[a*C_W +: C_W];
          if (req_last[a]) begin
            m_locked = 1'b0;
            m_last   = a;
          end else begin
            m_locked = 1'b1;
            m_owner  = a;
            m_idle   = 0;
          end
        end else begin
          e_plot = 1'b0;
          if (m_locked) begin
            m_idle++;
            if (m_idle == LOCK_TIMEOUT) begin
              m_locked = 1'b0;
              e_terr   = 1'b1;
              m_last   = m_owner;
            end
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_colour = '0;
    repeat (3) next();
    reset_n = 1'b1;

    // Reset state with no requests.
    settle();
    check("rst plot", 32'(plot), 32'd0);
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(req_ready), 32'd0);
    next();

    // Requester 2 single beat.
    set_req(2, 1, 1, 10, 20, 2);
    settle();
    check("r2 ready", 32'(req_ready), 32'b100);
    next();
    set_req(2, 0, 0, 0, 0, 0);
    settle();
    check("r2 plot", 32'(plot), 32'd1);
    check("r2 x", 32'(x_out), 32'd10);
    check("r2 y", 32'(y_out), 32'd20);
    check("r2 colour", 32'(colour_out), 32'b010);
    check("r2 busy", 32'(busy), 32'd0);
    next();

    // Requester 1 four-beat burst; requester 0 waits from beat 2.
    set_req(1, 1, 0, 30, 40, 5);
    settle();
    check("b1 ready", 32'(req_ready), 32'b010);
    next();
    set_req(1, 1, 0, 31, 40, 5);
    set_req(0, 1, 1, 50, 50, 1);
    settle();
    check("b2 ready", 32'(req_ready), 32'b010);
    check("b2 gnt", 32'(gnt), 32'b010);
    check("b2 x", 32'(x_out), 32'd30);
    next();
    set_req(1, 1, 0, 32, 40, 5);
    settle();
    check("b3 ready", 32'(req_ready), 32'b010);
    next();
    set_req(1, 1, 1, 33, 40, 5);
    settle();
    check("b4 ready", 32'(req_ready), 32'b010);
    check("b4 gnt", 32'(gnt), 32'b010);
    next();
    set_req(1, 0, 0, 0, 0, 0);
    settle();
    check("b5 ready", 32'(req_ready), 32'b001);
    check("b5 gnt", 32'(gnt), 32'b000);
    check("b5 x", 32'(x_out), 32'd33);
    check("b5 plot", 32'(plot), 32'd1);
    next();
    set_req(0, 0, 0, 0, 0, 0);
    settle();
    check("b6 x", 32'(x_out), 32'd50);
    check("b6 plot", 32'(plot), 32'd1);
    next();

    // Clipping boundaries.
    set_req(0, 1, 1, 160, 5, 7);
    next();
    set_req(0, 1, 1, 159, 119, 6);
    settle();
    check("clip x160 plot", 32'(plot), 32'd0);
    check("clip x160 x", 32'(x_out), 32'd160);
    next();
    set_req(0, 1, 1, 0, 120, 6);
    settle();
    check("edge 159/119 plot", 32'(plot), 32'd1);
    next();
    set_req(0, 0, 0, 0, 0, 0);
    settle();
    check("clip y120 plot", 32'(plot), 32'd0);
    check("clip y120 y", 32'(y_out), 32'd120);
    next();

    // Timeout after 64 silent cycles; requester 2 is waiting.
    set_req(1, 1, 0, 1, 1, 1);
    next();
    set_req(1, 0, 0, 0, 0, 0);
    set_req(2, 1, 1, 7, 8, 4);
    settle();
    check("to gnt", 32'(gnt), 32'b010);
    repeat (63) next();
    settle();
    check("to last busy", 32'(busy), 32'd1);
    check("to last ready", 32'(req_ready), 32'b010);
    check("to last err", 32'(timeout_err), 32'd0);
    next();
    settle();
    check("to err", 32'(timeout_err), 32'd1);
    check("to busy", 32'(busy), 32'd0);
    check("to r2 ready", 32'(req_ready), 32'b100);
    next();
    set_req(2, 0, 0, 0, 0, 0);
    settle();
    check("to err drop", 32'(timeout_err), 32'd0);
    check("to r2 x", 32'(x_out), 32'd7);
    next();

    // Last beat on the 64th cycle of the lock: normal release.
    set_req(1, 1, 0, 2, 2, 2);
    next();
    set_req(1, 0, 0, 0, 0, 0);
    repeat (63) next();
    set_req(1, 1, 1, 4, 4, 3);
    settle();
    check("tl ready", 32'(req_ready), 32'b010);
    next();
    set_req(1, 0, 0, 0, 0, 0);
    settle();
    check("tl err", 32'(timeout_err), 32'd0);
    check("tl plot", 32'(plot), 32'd1);
    check("tl x", 32'(x_out), 32'd4);
    check("tl busy", 32'(busy), 32'd0);
    next();

    // Reset mid-burst drops plot and the lock asynchronously.
    set_req(0, 1, 0, 3, 3, 3);
    next();
    set_req(0, 0, 0, 0, 0, 0);
    settle();
    check("mr plot before", 32'(plot), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mr plot", 32'(plot), 32'd0);
    check("mr busy", 32'(busy), 32'd0);
    check("mr gnt", 32'(gnt), 32'd0);
    next();
    next();
    reset_n = 1'b1;
    next();

    // All three requesters stream single beats.
    for (int i = 0; i < 3; i++) set_req(i, 1, 1, 10 * i + 1, i + 1, i + 1);
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("order %0d", k), 32'(req_ready), RR ? 32'(3'b001 << (k % 3)) : 32'b001);
      next();
    end
    for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0, 0, 0);
    repeat (2) next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
